// File: rtl/adc_sample_monitor.sv
// adc_sample_monitor
// Per-channel ADC sample activity monitor: stretches one-cycle `ready`
// strobes into LED pulses, keeps saturating sample counters and a sticky
// "sample seen" flag for every channel.
// Optional watchdog: define ADC_MON_WATCHDOG_EN to build the per-channel
// watchdog counters and the STALE state; otherwise `timeout` is tied low
// and TIMEOUT_CYCLES has no effect on the logic.
module adc_sample_monitor #(
    parameter int NUM_CH         = 1,
    parameter int HOLD_CYCLES    = 100,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       ready,
    input  logic                    clear,
    output logic [NUM_CH-1:0]       led,
    output logic [NUM_CH-1:0]       seen,
    output logic [NUM_CH-1:0]       timeout,
    output logic [NUM_CH*CNT_W-1:0] sample_count
);

    // Hold counter only ever holds 0 .. HOLD_CYCLES-1.
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_HOLD  = 2'd1,
        S_SEEN  = 2'd2,
        S_STALE = 2'd3
    } state_t;

    // Reject unusable parameter sets at elaboration time.
    if (NUM_CH < 1 || NUM_CH > 8 || HOLD_CYCLES < 1 || CNT_W < 2 ||
        TIMEOUT_CYCLES <= HOLD_CYCLES) begin : g_param_check
        $error("adc_sample_monitor: illegal parameter combination");
    end

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

`ifdef ADC_MON_WATCHDOG_EN
    // Watchdog counter only ever holds 0 .. TIMEOUT_CYCLES-1.
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t             state;
        logic [HOLD_W-1:0]  hold;
        logic [CNT_W-1:0]   count;
        logic               seen_r;
`ifdef ADC_MON_WATCHDOG_EN
        logic [WD_W-1:0]    wd;

        // Channel FSM with hold, watchdog and sample counters; clear/rst beat a same-cycle strobe.
        always_ff @(posedge clk) begin
            if (rst || clear) begin
                state  <= S_WAIT;
                hold   <= '0;
                wd     <= '0;
                count  <= '0;
                seen_r <= 1'b0;
            end else if (ready[i]) begin
                state  <= S_HOLD;
                hold   <= HOLD_LOAD;
                wd     <= '0;
                count  <= sat_inc(count);
                seen_r <= 1'b1;
            end else begin
                // End of LED pulse takes precedence over watchdog expiry.
                if (state == S_HOLD && hold == '0) begin
                    state <= S_SEEN;
                end else if (state != S_STALE && wd == WD_LAST) begin
                    state <= S_STALE;
                end
                if (state == S_HOLD && hold != '0) begin
                    hold <= hold - 1'b1;
                end
                // Watchdog freezes once the channel is stale.
                if (state != S_STALE && wd != WD_LAST) begin
                    wd <= wd + 1'b1;
                end
            end
        end

        assign timeout[i] = (state == S_STALE);
`else
        // Channel FSM with hold and sample counters; clear/rst beat a same-cycle strobe.
        always_ff @(posedge clk) begin
            if (rst || clear) begin
                state  <= S_WAIT;
                hold   <= '0;
                count  <= '0;
                seen_r <= 1'b0;
            end else if (ready[i]) begin
                state  <= S_HOLD;
                hold   <= HOLD_LOAD;
                count  <= sat_inc(count);
                seen_r <= 1'b1;
            end else if (state == S_HOLD) begin
                if (hold == '0) begin
                    state <= S_SEEN;
                end else begin
                    hold <= hold - 1'b1;
                end
            end
        end

        assign timeout[i] = 1'b0;
`endif

        // Outputs decode straight from channel registers.
        assign led[i]                          = (state == S_HOLD);
        assign seen[i]                         = seen_r;
        assign sample_count[i*CNT_W +: CNT_W]  = count;
    end

endmodule

// File: tb/tb_adc_sample_monitor.sv
// tb_adc_sample_monitor
// Directed bench for adc_sample_monitor with NUM_CH=2, HOLD_CYCLES=4,
// CNT_W=3, TIMEOUT_CYCLES=16. Timeout expectations follow the build:
// with ADC_MON_WATCHDOG_EN defined the watchdog windows are expected,
// otherwise timeout must stay 0.
module tb_adc_sample_monitor;

    localparam int NUM_CH         = 2;
    localparam int HOLD_CYCLES    = 4;
    localparam int CNT_W          = 3;
    localparam int TIMEOUT_CYCLES = 16;

`ifdef ADC_MON_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    clear = 1'b0;
    logic [NUM_CH-1:0]       ready = '0;
    logic [NUM_CH-1:0]       led;
    logic [NUM_CH-1:0]       seen;
    logic [NUM_CH-1:0]       timeout;
    logic [NUM_CH*CNT_W-1:0] sample_count;
    logic [CNT_W-1:0]        count0;
    logic [CNT_W-1:0]        count1;

    int cyc   = 0;
    int n_cmp = 0;
    int n_err = 0;

    assign count0 = sample_count[CNT_W-1:0];
    assign count1 = sample_count[2*CNT_W-1:CNT_W];

    adc_sample_monitor #(
        .NUM_CH         (NUM_CH),
        .HOLD_CYCLES    (HOLD_CYCLES),
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ready        (ready),
        .clear        (clear),
        .led          (led),
        .seen         (seen),
        .timeout      (timeout),
        .sample_count (sample_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    // Advance one clock; outputs are then stable for cycle `cyc`.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Reset with strobes asserted (they must be dropped); cycle 0 is the
    // first cycle with rst low.
    task automatic do_reset();
        rst   = 1'b1;
        clear = 1'b0;
        ready = '1;
        repeat (3) @(posedge clk);
        #1;
        rst   = 1'b0;
        ready = '0;
        cyc   = 0;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_led",     led,     0);
        check("rst_seen",    seen,    0);
        check("rst_timeout", timeout, 0);
        check("rst_cnt0",    count0,  0);
        check("rst_cnt1",    count1,  0);

        // Single strobe on ch0 at 10, idle, then strobe at 40 out of STALE
        while (cyc < 46) begin
            ready[0] = (cyc == 10 || cyc == 40);
            tick();
            check("s1_led0",  led[0],  (cyc >= 11 && cyc <= 14) || (cyc >= 41 && cyc <= 44));
            check("s1_seen0", seen[0], cyc >= 11);
            check("s1_cnt0",  count0,  (cyc >= 41) ? 2 : (cyc >= 11) ? 1 : 0);
            check("s1_led1",  led[1],  0);
            check("s1_seen1", seen[1], 0);
            check("s1_cnt1",  count1,  0);
            check("s1_to0",   timeout[0], WD && cyc >= 27 && cyc <= 40);
            check("s1_to1",   timeout[1], WD && cyc >= 16);
        end
        ready = '0;

        // Retrigger during HOLD
        do_reset();
        while (cyc < 20) begin
            ready[0] = (cyc == 10 || cyc == 12);
            tick();
            check("s2_led0", led[0], cyc >= 11 && cyc <= 16);
            check("s2_cnt0", count0, (cyc >= 13) ? 2 : (cyc >= 11) ? 1 : 0);
        end
        ready = '0;

        // Nine strobes on ch1 every 5 cycles (5..45): count saturates at 7
        do_reset();
        while (cyc < 50) begin
            ready[1] = (cyc >= 5 && cyc <= 45 && cyc % 5 == 0);
            tick();
            check("s3_cnt1", count1, (cyc <= 5) ? 0 : (((cyc - 1) / 5 > 7) ? 7 : (cyc - 1) / 5));
            check("s3_led1", led[1], cyc >= 6 && cyc % 5 != 0);
            check("s3_to1",  timeout[1], 0);
        end
        ready = '0;

        // clear together with ready[1] at 20 after three strobes
        do_reset();
        while (cyc < 40) begin
            ready[1] = (cyc == 5 || cyc == 10 || cyc == 15 || cyc == 20);
            clear    = (cyc == 20);
            tick();
            check("s4_cnt1",  count1, (cyc >= 21) ? 0 : (cyc >= 16) ? 3 : (cyc >= 11) ? 2 : (cyc >= 6) ? 1 : 0);
            check("s4_seen1", seen[1], cyc >= 6 && cyc <= 20);
            check("s4_led1",  led[1], (cyc >= 6 && cyc <= 9) || (cyc >= 11 && cyc <= 14) || (cyc >= 16 && cyc <= 19));
            check("s4_to1",   timeout[1], WD && cyc >= 37);
            check("s4_to0",   timeout[0], WD && ((cyc >= 16 && cyc <= 20) || cyc >= 37));
        end
        ready = '0;
        clear = 1'b0;

        // Reset in the middle of an LED pulse
        do_reset();
        while (cyc < 12) begin
            ready[0] = (cyc == 3);
            rst      = (cyc == 5);
            tick();
            check("s5_led0",  led[0],  cyc >= 4 && cyc <= 5);
            check("s5_seen0", seen[0], cyc >= 4 && cyc <= 5);
            check("s5_cnt0",  count0,  (cyc >= 4 && cyc <= 5) ? 1 : 0);
        end
        ready = '0;
        rst   = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
